// File: rtl/l2_cache_multiport.sv
// l2_cache_multiport
//   Read-only, direct-mapped L2 cache shared by NUM_PORTS L1 requesters.
//   A round-robin arbiter picks one request at a time. A hit answers from the
//   line store. A miss refills the whole line word by word from memory.
//   A flush pulse in IDLE invalidates every line. Hit and miss counters saturate.
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   req_access/req_address     per-port read request and byte address (port i at [i*XLEN +: XLEN])
//   req_word/req_word_valid    per-port returned word and one-cycle valid pulse
//   flush                      one-cycle whole-cache invalidate (honoured only in IDLE)
//   memory_address/access      refill word address and held refill request
//   memory_word/word_valid     refill data returned by memory
//   hit_count/miss_count       saturating event counters
module l2_cache_multiport #(
  parameter int XLEN      = 32,
  parameter int LINE_SIZE = 32,
  parameter int NUM_SETS  = 64,
  parameter int NUM_PORTS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PORTS-1:0]      req_access,
  input  logic [NUM_PORTS*XLEN-1:0] req_address,
  output logic [NUM_PORTS*XLEN-1:0] req_word,
  output logic [NUM_PORTS-1:0]      req_word_valid,
  input  logic                      flush,
  output logic [XLEN-1:0]           memory_address,
  output logic                      memory_access,
  input  logic [XLEN-1:0]           memory_word,
  input  logic                      memory_word_valid,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam int BPW  = XLEN / 8;
  localparam int WPL  = LINE_SIZE / BPW;
  localparam int BOFF = $clog2(BPW);
  localparam int WOFF = $clog2(WPL);
  localparam int IDXW = $clog2(NUM_SETS);
  localparam int TAGW = XLEN - BOFF - WOFF - IDXW;
  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, REFILL = 2'd2, RESPOND = 2'd3} state_t;

  state_t          state;
  state_t          next_state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   grant_idx;
  logic            any_req;
  logic [XLEN-1:0] addr;
  logic [WOFF-1:0] cnt;
  logic [WOFF-1:0] cnt_next;
  logic [XLEN-1:0] resp_data;
  logic [NUM_SETS-1:0] line_valid;
  logic [TAGW-1:0] tags [NUM_SETS];
  logic [XLEN-1:0] data [NUM_SETS*WPL];

  // Fields of the request currently in service
  logic [WOFF-1:0] lk_off;
  logic [IDXW-1:0] lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            hit;
  logic            last_word;
  logic            unused_byte_bits;

  assign lk_off    = addr[BOFF +: WOFF];
  assign lk_idx    = addr[BOFF+WOFF +: IDXW];
  assign lk_tag    = addr[XLEN-1 -: TAGW];
  assign hit       = line_valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign last_word = (cnt == WOFF'(WPL-1));
  assign cnt_next  = cnt + WOFF'(1);
  assign unused_byte_bits = ^addr[BOFF-1:0];

  // Round-robin pick: lowest rotation distance from rr wins (loop runs downward)
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      if (req_access[(int'(rr) + k) % NUM_PORTS]) begin
        any_req   = 1'b1;
        grant_idx = PW'((int'(rr) + k) % NUM_PORTS);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; flush in IDLE takes priority over a grant
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!flush && any_req) next_state = LOOKUP;
      LOOKUP:  next_state = hit ? RESPOND : REFILL;
      REFILL:  if (memory_word_valid && last_word) next_state = RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and control datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      rr             <= '0;
      grant          <= '0;
      addr           <= '0;
      cnt            <= '0;
      resp_data      <= '0;
      line_valid     <= '0;
      req_word       <= '0;
      req_word_valid <= '0;
      memory_address <= '0;
      memory_access  <= 1'b0;
      hit_count      <= 32'd0;
      miss_count     <= 32'd0;
    end else begin
      req_word_valid <= '0;
      case (state)
        IDLE: begin
          if (flush) begin
            line_valid <= '0;
          end else if (any_req) begin
            grant <= grant_idx;
            addr  <= req_address[int'(grant_idx)*XLEN +: XLEN];
            rr    <= (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + PW'(1);
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            resp_data <= data[{lk_idx, lk_off}];
          end else begin
            if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            cnt            <= '0;
            memory_access  <= 1'b1;
            memory_address <= {lk_tag, lk_idx, {WOFF{1'b0}}, {BOFF{1'b0}}};
          end
        end
        REFILL: begin
          if (memory_word_valid) begin
            if (cnt == lk_off) resp_data <= memory_word;
            if (last_word) begin
              line_valid[lk_idx] <= 1'b1;
              memory_access      <= 1'b0;
            end else begin
              cnt            <= cnt_next;
              memory_address <= {lk_tag, lk_idx, cnt_next, {BOFF{1'b0}}};
            end
          end
        end
        RESPOND: begin
          req_word[int'(grant)*XLEN +: XLEN] <= resp_data;
          req_word_valid[grant]              <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line store: refill writes only; a reset on the same edge discards the word
  always_ff @(posedge clk) begin
    if (!reset && state == REFILL && memory_word_valid) begin
      data[{lk_idx, cnt}] <= memory_word;
      if (last_word) tags[lk_idx] <= lk_tag;
    end
  end

endmodule
